binary_to_bcd: RTL
==================

# binary_to_bcd

Sequential double-dabble converter: turns an unsigned binary value into packed BCD digits, one shift-and-adjust step per clock. It produces the 4-bit per-digit codes that the 7-segment decoders consume, for example to show the 8-bit accumulator or bus value as decimal on the board display. It uses a start/busy/done handshake, and the result is held stable between conversions.

## Interface
- WIDTH, 8: binary input width in bits.
- DIGITS, 3: BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH − 1; checked by elaboration-time assertion.
- Clk  input  1  clock; all logic on the rising edge.
- Rst  input  1  reset. Synchronous and active-high.
- Start  input  1  conversion request; sampled only in IDLE or DONE.
- Binary_in  input  WIDTH  value to convert; captured only on an accepted Start.
- Busy  output  1  high while a conversion is in progress.
- Done  output  1  one-cycle pulse when Bcd_out has just been updated.
- Bcd_out  output  4*DIGITS  packed result. Digit 0 (units) is in [3:0], digit 1 in [7:4], and so on.

## Operation
- States:
  - IDLE: wait for Start.
  - SHIFT: run WIDTH iterations.
  - DONE: one cycle; present the result.
- IDLE, Start=1 → SHIFT.
  - Load the internal scratch register as {DIGITS*4 zeros, Binary_in}.
  - Iteration counter = 0.
- SHIFT, each cycle:
  - Every BCD digit field ≥ 5 gets +3 (combinational, all digits in parallel).
  - The whole scratch register then shifts left by 1.
  - Counter increments.
  - When the counter reaches WIDTH−1 in this cycle → DONE.
- Entering DONE: Bcd_out ← the upper 4*DIGITS bits of the scratch register after the final shift; Done=1.
- DONE, Start=1 → SHIFT, loading the new Binary_in (back-to-back conversions). Start=0 → IDLE.
- Start in SHIFT is ignored. It is not queued.
- Bcd_out changes only on entry to DONE. It holds its value through IDLE and the next SHIFT phase.
- Every digit of Bcd_out is always in 0–9. No value in 10–15 is ever produced.
- Counter width: $clog2(WIDTH), minimum 1 bit. No wrap occurs within a conversion.

## Timing
- Reset values: state IDLE, Busy=0, Done=0, Bcd_out=0, scratch=0, counter=0.
- Busy=1 exactly in SHIFT; Busy=0 in IDLE and DONE.
- Done=1 exactly in DONE.
- Latency, with Start sampled at edge n:
  - Busy is high for cycles n+1 … n+WIDTH.
  - Done and the new Bcd_out are visible in cycle n+WIDTH+1 (WIDTH=8: 9 clocks).
- Sustained throughput with Start held high: one result every WIDTH+1 clocks.
- Rst=1 at any edge, including mid-SHIFT: the conversion is aborted and all registers return to reset values on that edge. Start is ignored during reset.
- Rst and Start high in the same cycle: reset wins.

## Structure
- Package bcd_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;
  - localparam BCD_DIGIT_W = 4;
  - localparam BCD_ADJ_THRESH = 4'd5; localparam BCD_ADJ_ADD = 4'd3.
- Sub-module bcd_digit_adjust: combinational 4-bit in → 4-bit out, +3 when ≥5. Instantiated DIGITS times via generate.
- Top level holds the FSM, counter, scratch register and output register.

## Test plan
- Reset, then Start with Binary_in=8'd0 → Done at cycle n+9, Bcd_out=12'h000, Busy high for exactly 8 cycles.
- Binary_in=8'd255 → Bcd_out=12'h255. Binary_in=8'd100 → 12'h100. Binary_in=8'd9 → 12'h009. Exhaustive sweep 0–255 against a reference model; no digit ever exceeds 9.
- Start=1 held continuously with inputs 37 then 200 → Done pulses 9 cycles apart, Bcd_out 12'h037 then 12'h200, no idle cycle between conversions.
- Start pulsed again at cycles n+3 with Binary_in=8'd77 during a conversion of 8'd142 → ignored; result 12'h142, FSM returns to IDLE.
- Rst asserted at cycle n+4 mid-conversion → next cycle Busy=0, Done=0, Bcd_out=12'h000. The following Start of 8'd58 completes normally with 12'h058.
- Parameter variant WIDTH=4, DIGITS=2, Binary_in=4'd15 → Bcd_out=8'h15, Done at n+5.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_ADD    = 4'd3;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One double-dabble correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_ADJ_THRESH) digit_o = digit_i + BCD_ADJ_ADD;
  end

endmodule

// File: rtl/binary_to_bcd.sv
// Sequential double-dabble converter: one adjust-and-shift step per clock,
// start/busy/done handshake, result held between conversions.
module binary_to_bcd
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          Start,
  input  logic [WIDTH-1:0]              Binary_in,
  output logic                          Busy,
  output logic                          Done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] Bcd_out
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SCR_W = BCD_W + WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_digits
    $error("binary_to_bcd: DIGITS too small to represent 2^WIDTH-1");
  end

  bcd_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SCR_W-1:0] scr_q, scr_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [SCR_W-1:0] scr_adj;
  logic [SCR_W-1:0] scr_shift;

  // Binary part passes through untouched; every digit field is corrected in parallel.
  assign scr_adj[WIDTH-1:0] = scr_q[WIDTH-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i(scr_q  [WIDTH + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o(scr_adj[WIDTH + g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign scr_shift = {scr_adj[SCR_W-2:0], 1'b0};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = SHIFT;
          scr_d   = {{BCD_W{1'b0}}, Binary_in};
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        scr_d = scr_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          bcd_d   = scr_shift[SCR_W-1 -: BCD_W];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
    end
  end

  assign Busy    = (state_q == SHIFT);
  assign Done    = (state_q == DONE);
  assign Bcd_out = bcd_q;

endmodule
